raster_scheduler: RTL and testbench

//  Frame-level sequencer in front of the rasterizer. Queues triangle descriptors from MicroBlaze in a FIFO.

---
 rtl/raster_scheduler_pkg.sv | 34 +++
 rtl/raster_scheduler_if.sv | 23 ++
 rtl/raster_scheduler_fifo.sv | 56 +++++
 rtl/raster_scheduler.sv | 132 +++++++++++++
 tb/tb_raster_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/raster_scheduler_pkg.sv
// Shared types and constants for the frame-level raster scheduler.
package raster_scheduler_pkg;

  localparam int TRI_W      = 230;
  localparam int FB_W       = 320;
  localparam int FB_H       = 240;
  localparam int FB_WORDS   = FB_W * FB_H;
  localparam int FIFO_DEPTH = 8;
  localparam int CLR_AW     = 17;

  localparam logic [7:0] CLEAR_COLOR = 8'h00;
  localparam logic [7:0] CLEAR_Z     = 8'hFF;

  // Triangle descriptor as written by the MicroBlaze, MSB first.
  typedef struct packed {
    logic [31:0] inv_area;
    logic [7:0]  color;
    logic [8:0]  a1, a2, a3;
    logic [8:0]  b1, b2, b3;
    logic [17:0] c1, c2, c3;
    logic [8:0]  bb_xmin, bb_xmax;
    logic [7:0]  bb_ymin, bb_ymax;
    logic [15:0] z1, z2, z3;
  } tri_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READY,
    S_BUSY,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/raster_scheduler_if.sv
// Descriptor intake and rasterizer handshake bundle.
// master = descriptor source / rasterizer side, slave = the scheduler.
interface raster_scheduler_if;
  import raster_scheduler_pkg::*;

  logic      tri_valid;
  logic      tri_ready;
  tri_desc_t tri_data;
  tri_desc_t rast_tri;
  logic      rasterizer_start;
  logic      rasterizer_done;

  modport master (
    output tri_valid, tri_data, rasterizer_done,
    input  tri_ready, rast_tri, rasterizer_start
  );

  modport slave (
    input  tri_valid, tri_data, rasterizer_done,
    output tri_ready, rast_tri, rasterizer_start
  );

endinterface

// File: rtl/raster_scheduler_fifo.sv
// Triangle queue: register-based FIFO with a combinational head, so the
// scheduler can latch the head in the same cycle it pops.
module raster_scheduler_fifo
  import raster_scheduler_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  tri_desc_t i_din,
  input  logic      i_pop,
  output tri_desc_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  tri_desc_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  // A full queue refuses the push even if the same cycle pops.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// Frame sequencer: clears FB/zbuf, then feeds queued triangles to the
// rasterizer one at a time, and flags frame completion after frame_end.
//
//  state   | meaning
//  S_IDLE  | waiting for frame_start
//  S_CLEAR | writing clear values, one word per cycle
//  S_READY | pop next triangle, or finish if frame_end seen and queue empty
//  S_BUSY  | one triangle in flight, waiting for rasterizer_done
//  S_DONE  | frame_done pulse, back to idle
module raster_scheduler
  import raster_scheduler_pkg::*;
#(
  parameter int CLEAR_WORDS = FB_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  raster_scheduler_if.slave  bus,
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  output logic               o_clearing,
  output logic               o_clr_we,
  output logic [CLR_AW-1:0]  o_clr_addr,
  output logic [7:0]         o_clr_fb_data,
  output logic [7:0]         o_clr_z_data,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic [15:0]        o_tri_count
);

  localparam logic [CLR_AW-1:0] LAST_ADDR = CLR_AW'(CLEAR_WORDS - 1);

  sched_state_t      r_state;
  sched_state_t      w_next;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  tri_desc_t         w_head;
  tri_desc_t         r_rast_tri;
  logic              r_start;
  logic              r_frame_done;
  logic              r_end_pending;
  logic [CLR_AW-1:0] r_clr_addr;
  logic [15:0]       r_tri_count;

  raster_scheduler_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.tri_valid),
    .i_din   (bus.tri_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; the pop doubles as the issue decision.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:  if (i_frame_start) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_addr == LAST_ADDR) w_next = S_READY;
      S_READY: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_BUSY;
        end else if (r_end_pending) begin
          w_next = S_DONE;
        end
      end
      S_BUSY:  if (bus.rasterizer_done) w_next = S_READY;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs, clear address, frame bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rast_tri    <= '0;
      r_start       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_end_pending <= 1'b0;
      r_clr_addr    <= '0;
      r_tri_count   <= '0;
    end else begin
      r_start      <= w_pop;
      r_frame_done <= (w_next == S_DONE);
      if (w_pop) begin
        r_rast_tri <= w_head;
        if (r_tri_count != 16'hFFFF) r_tri_count <= r_tri_count + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_clr_addr    <= '0;
            r_tri_count   <= '0;
            r_end_pending <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (r_clr_addr != LAST_ADDR) r_clr_addr <= r_clr_addr + 1'b1;
          if (i_frame_end) r_end_pending <= 1'b1;
        end
        S_READY, S_BUSY: begin
          if (i_frame_end) r_end_pending <= 1'b1;
        end
        S_DONE:  r_end_pending <= 1'b0;
        default: r_end_pending <= r_end_pending;
      endcase
    end
  end

  assign bus.tri_ready        = !w_full;
  assign bus.rast_tri         = r_rast_tri;
  assign bus.rasterizer_start = r_start;
  assign o_clearing           = (r_state == S_CLEAR);
  assign o_clr_we             = (r_state == S_CLEAR);
  assign o_clr_addr           = r_clr_addr;
  assign o_clr_fb_data        = CLEAR_COLOR;
  assign o_clr_z_data         = CLEAR_Z;
  assign o_frame_done         = r_frame_done;
  assign o_busy               = (r_state != S_IDLE);
  assign o_tri_count          = r_tri_count;

endmodule

// File: tb/tb_raster_scheduler.sv
// Directed-sequence bench with random descriptors; expected issue order,
// queue occupancy and pulse timing come from a queue-based model.
module tb_raster_scheduler;
  import raster_scheduler_pkg::*;

  localparam int NCLR     = 64;
  localparam int DEPTH    = FIFO_DEPTH;
  localparam int DONE_LAT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        clearing, clr_we, frame_done, busy;
  logic [16:0] clr_addr;
  logic [7:0]  clr_fb, clr_z;
  logic [15:0] tri_count;

  raster_scheduler_if bus ();

  raster_scheduler #(.CLEAR_WORDS(NCLR)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .i_frame_start (frame_start),
    .i_frame_end   (frame_end),
    .o_clearing    (clearing),
    .o_clr_we      (clr_we),
    .o_clr_addr    (clr_addr),
    .o_clr_fb_data (clr_fb),
    .o_clr_z_data  (clr_z),
    .o_frame_done  (frame_done),
    .o_busy        (busy),
    .o_tri_count   (tri_count)
  );

  always #5 clk = ~clk;

  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  tri_desc_t q_exp [$];
  bit        auto_done = 0;
  bit        force_done = 0;
  int        done_due = -1;
  int        last_done = -1;
  bit        done_since_start = 0;
  int        n_start = 0;
  int        fd_count = 0;
  int        fd_cyc = -1;
  bit        acc = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tri_desc_t rand_desc();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return tri_desc_t'(v[TRI_W-1:0]);
  endfunction

  // One clock: observe at negedge, drive rasterizer_done, update model at posedge.
  task automatic cycle();
    tri_desc_t e;
    @(negedge clk);
    if (!rst) begin
      if (bus.rasterizer_start) begin
        n_start++;
        chk("start_has_entry", 256'(q_exp.size() > 0), 256'(1));
        if (q_exp.size() > 0) begin
          e = q_exp.pop_front();
          chk("rast_tri", 256'(bus.rast_tri), 256'(e));
        end
        if (done_since_start) chk("start_gap", 256'(cyc - last_done), 256'(2));
        done_since_start = 0;
        if (auto_done) done_due = cyc + DONE_LAT;
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      chk("tri_ready", 256'(bus.tri_ready), 256'(q_exp.size() < DEPTH));
    end
    acc = bus.tri_valid && bus.tri_ready && !rst;
    bus.rasterizer_done = force_done || (auto_done && cyc == done_due);
    if (bus.rasterizer_done) begin
      last_done = cyc;
      done_since_start = 1;
    end
    @(posedge clk);
    cyc++;
    if (acc) q_exp.push_back(bus.tri_data);
    #1;
  endtask

  task automatic push(input tri_desc_t d, input int budget, output bit ok);
    bus.tri_valid = 1'b1;
    bus.tri_data  = d;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      cycle();
      ok = acc;
    end
    bus.tri_valid = 1'b0;
  endtask

  task automatic new_frame(input bit with_end);
    frame_start = 1'b1;
    frame_end   = with_end;
    cycle();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    last_done = -1;
    done_since_start = 0;
    n_start = 0;
    fd_count = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit        ok;
    int        fe;
    int        ns;
    tri_desc_t d9;

    bus.tri_valid = 1'b0;
    bus.tri_data  = '0;
    bus.rasterizer_done = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    chk("rst_busy",      256'(busy), 256'(0));
    chk("rst_ready",     256'(bus.tri_ready), 256'(1));
    chk("rst_start",     256'(bus.rasterizer_start), 256'(0));
    chk("rst_fdone",     256'(frame_done), 256'(0));
    chk("rst_clr_we",    256'(clr_we), 256'(0));
    chk("rst_clearing",  256'(clearing), 256'(0));
    chk("rst_tri_count", 256'(tri_count), 256'(0));
    chk("rst_rast_tri",  256'(bus.rast_tri), 256'(0));
    chk("clr_fb_data",   256'(clr_fb), 256'(8'h00));
    chk("clr_z_data",    256'(clr_z), 256'(8'hFF));

    // Frame 1: clear sweep, three preloaded triangles, mid-clear frame_start ignored
    auto_done = 1;
    new_frame(0);
    for (int i = 0; i < NCLR; i++) begin
      chk("clr_we",   256'(clr_we), 256'(1));
      chk("clr_addr", 256'(clr_addr), 256'(i));
      if (i == 0) chk("clearing", 256'(clearing), 256'(1));
      if (i >= 5 && i <= 7) begin
        bus.tri_valid = 1'b1;
        bus.tri_data  = rand_desc();
      end else begin
        bus.tri_valid = 1'b0;
      end
      frame_start = (i == 20);
      cycle();
    end
    bus.tri_valid = 1'b0;
    frame_start = 1'b0;
    chk("clear_end_we",   256'(clr_we), 256'(0));
    chk("clear_end_busy", 256'(busy), 256'(1));
    for (int k = 0; k < 200 && !(n_start == 3 && done_since_start); k++) cycle();
    chk("f1_starts",    256'(n_start), 256'(3));
    chk("f1_tri_count", 256'(tri_count), 256'(3));
    repeat (3) cycle();

    // Frame end with empty queue in S_READY
    fe = cyc;
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
    repeat (6) cycle();
    chk("f1_fd_count", 256'(fd_count), 256'(1));
    chk("f1_fd_lat",   256'(fd_cyc - fe), 256'(2));
    chk("f1_idle",     256'(busy), 256'(0));

    // frame_end in idle is ignored
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
    repeat (3) cycle();
    chk("idle_fe_ignored", 256'(fd_count), 256'(1));

    // Frame 2: start+end together, then backpressure
    auto_done = 0;
    new_frame(1);
    repeat (NCLR + 3) cycle();
    chk("f2_no_early_done", 256'(fd_count), 256'(0));
    chk("f2_count_reset",   256'(tri_count), 256'(0));
    chk("f2_busy",          256'(busy), 256'(1));
    for (int j = 0; j < 9; j++) begin
      push(rand_desc(), 4, ok);
      chk("bp_push_ok", 256'(ok), 256'(1));
    end
    d9 = rand_desc();
    push(d9, 12, ok);
    chk("bp_tenth_blocked", 256'(ok), 256'(0));
    chk("bp_ready_low",     256'(bus.tri_ready), 256'(0));
    chk("bp_one_issued",    256'(n_start), 256'(1));
    bus.tri_valid = 1'b1;
    bus.tri_data  = d9;
    force_done = 1;
    auto_done  = 1;
    cycle();
    force_done = 0;
    ok = acc;
    for (int k = 0; k < 6 && !ok; k++) begin
      cycle();
      ok = acc;
    end
    bus.tri_valid = 1'b0;
    chk("bp_tenth_accepted", 256'(ok), 256'(1));
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
    for (int k = 0; k < 400 && fd_count == 0; k++) cycle();
    repeat (4) cycle();
    chk("f2_fd_count",  256'(fd_count), 256'(1));
    chk("f2_fd_lat",    256'(fd_cyc - last_done), 256'(2));
    chk("f2_starts",    256'(n_start), 256'(10));
    chk("f2_tri_count", 256'(tri_count), 256'(10));
    chk("f2_drained",   256'(q_exp.size()), 256'(0));

    // Frame 3: reset while busy with queued work
    auto_done = 0;
    new_frame(0);
    repeat (NCLR + 2) cycle();
    for (int j = 0; j < 4; j++) begin
      push(rand_desc(), 4, ok);
      chk("f3_push_ok", 256'(ok), 256'(1));
    end
    repeat (3) cycle();
    chk("f3_pre_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    cycle();
    q_exp.delete();
    rst = 1'b0;
    chk("mid_rst_busy",  256'(busy), 256'(0));
    chk("mid_rst_ready", 256'(bus.tri_ready), 256'(1));
    chk("mid_rst_start", 256'(bus.rasterizer_start), 256'(0));
    chk("mid_rst_count", 256'(tri_count), 256'(0));
    ns = n_start;
    repeat (10) cycle();
    chk("mid_rst_no_start", 256'(n_start), 256'(ns));

    // Queue must be empty after reset: a fresh frame issues nothing
    auto_done = 1;
    new_frame(0);
    repeat (NCLR + 10) cycle();
    chk("post_rst_no_issue", 256'(n_start), 256'(0));
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
    repeat (5) cycle();
    chk("post_rst_fd", 256'(fd_count), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
